// File: rtl/reg_writeback.sv
// reg_writeback: register-file writeback stage for one core thread.
//
// During the UPDATE core phase (core_state == 3'b110) it selects the result
// source (ALU, LSU load data or immediate), waits a bounded time for load
// data if needed, and performs one valid/ready write into the register file.
// All outputs are registered.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   enable                      thread active; low freezes all state
//   core_state                  core phase, 3'b110 = UPDATE
//   decoded_*                   write enable, source mux, rd, immediate
//   alu_out, lsu_out, lsu_valid result sources
//   wb_ready / wb_valid         write handshake with the register file
//   wb_address, wb_data         write target and value
//   wb_done, wb_error           phase complete / illegal, timed-out or aborted
//   wb_count                    saturating count of completed writes
module reg_writeback #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [3:0]           decoded_rd_address,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  input  logic                 lsu_valid,
  input  logic                 wb_ready,
  output logic                 wb_valid,
  output logic [3:0]           wb_address,
  output logic [DATA_BITS-1:0] wb_data,
  output logic                 wb_done,
  output logic                 wb_error,
  output logic [7:0]           wb_count
);

  localparam logic [2:0] CoreUpdate = 3'b110;
  localparam logic [1:0] MuxArith   = 2'b00;
  localparam logic [1:0] MuxMemory  = 2'b01;
  localparam logic [1:0] MuxConst   = 2'b10;
  localparam logic [7:0] WaitLast   = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWaitMem, StWrite, StDone} state_e;

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [3:0]           addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [7:0]           count_q, count_d;
  logic [7:0]           wait_q, wait_d;

  logic in_update;
  assign in_update = (core_state == CoreUpdate);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    error_d = error_q;
    count_d = count_q;
    wait_d  = wait_q;

    unique case (state_q)
      StIdle: begin
        // An abort error pulse lasts only the one cycle spent entering IDLE.
        done_d  = 1'b0;
        error_d = 1'b0;
        if (in_update) begin
          if (!decoded_reg_write_enable) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (decoded_rd_address >= 4'd13 ||
                       decoded_reg_input_mux == 2'b11) begin
            state_d = StDone;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            addr_d = decoded_rd_address;
            if (decoded_reg_input_mux == MuxArith) begin
              data_d  = alu_out;
              valid_d = 1'b1;
              state_d = StWrite;
            end else if (decoded_reg_input_mux == MuxConst) begin
              data_d  = decoded_immediate;
              valid_d = 1'b1;
              state_d = StWrite;
            end else if (decoded_reg_input_mux == MuxMemory && lsu_valid) begin
              data_d  = lsu_out;
              valid_d = 1'b1;
              state_d = StWrite;
            end else begin
              wait_d  = 8'd0;
              state_d = StWaitMem;
            end
          end
        end
      end

      StWaitMem: begin
        if (!in_update) begin
          state_d = StIdle;
          error_d = 1'b1;
        end else if (lsu_valid) begin
          data_d  = lsu_out;
          valid_d = 1'b1;
          state_d = StWrite;
        end else if (wait_q == WaitLast) begin
          state_d = StDone;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      StWrite: begin
        // A handshake wins over a simultaneous phase change: the write lands.
        if (valid_q && wb_ready) begin
          state_d = StDone;
          valid_d = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b0;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end else if (!in_update) begin
          state_d = StIdle;
          valid_d = 1'b0;
          error_d = 1'b1;
        end
      end

      StDone: begin
        if (!in_update) begin
          state_d = StIdle;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      addr_q  <= 4'd0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      count_q <= 8'd0;
      wait_q  <= 8'd0;
    end else if (enable) begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  assign wb_valid   = valid_q;
  assign wb_address = addr_q;
  assign wb_data    = data_q;
  assign wb_done    = done_q;
  assign wb_error   = error_q;
  assign wb_count   = count_q;

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

  localparam int KWrite = 0;
  localparam int KDone  = 1;
  localparam int KAbort = 2;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
    logic       err;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       we;
  logic [1:0] mux;
  logic [3:0] rd;
  logic [7:0] imm;
  logic [7:0] alu_out;
  logic [7:0] lsu_out;
  logic       lsu_valid;
  logic       wb_ready;
  logic       wb_valid;
  logic [3:0] wb_address;
  logic [7:0] wb_data;
  logic       wb_done;
  logic       wb_error;
  logic [7:0] wb_count;

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t ev_q[$];
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  always #5 clk = ~clk;

  reg_writeback #(.DATA_BITS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_reg_write_enable (we),
    .decoded_reg_input_mux    (mux),
    .decoded_rd_address       (rd),
    .decoded_immediate        (imm),
    .alu_out                  (alu_out),
    .lsu_out                  (lsu_out),
    .lsu_valid                (lsu_valid),
    .wb_ready                 (wb_ready),
    .wb_valid                 (wb_valid),
    .wb_address               (wb_address),
    .wb_data                  (wb_data),
    .wb_done                  (wb_done),
    .wb_error                 (wb_error),
    .wb_count                 (wb_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ev_t mk(input int kind, input logic [3:0] a, input logic [7:0] d,
                             input logic e);
    ev_t ev;
    ev.kind = kind;
    ev.addr = a;
    ev.data = d;
    ev.err  = e;
    return ev;
  endfunction

  task automatic set_op(input logic w, input logic [1:0] m, input logic [3:0] r,
                        input logic [7:0] i, input logic [7:0] a);
    we      = w;
    mux     = m;
    rd      = r;
    imm     = i;
    alu_out = a;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    ev_t exp_ev;
    if (reset === 1'b0 && enable === 1'b1) begin
      if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
        if (ev_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          exp_ev = ev_q.pop_front();
          chk("write_kind", KWrite, exp_ev.kind);
          chk("write_addr", {28'd0, wb_address}, {28'd0, exp_ev.addr});
          chk("write_data", {24'd0, wb_data}, {24'd0, exp_ev.data});
        end
      end
      if (wb_done === 1'b1 && !prev_done) begin
        if (ev_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_ev = ev_q.pop_front();
          chk("done_kind", KDone, exp_ev.kind);
          chk("done_error", {31'd0, wb_error}, {31'd0, exp_ev.err});
        end
      end
      if (wb_error === 1'b1 && wb_done === 1'b0 && !prev_err) begin
        if (ev_q.size() == 0) chk("unexpected_abort", 1, 0);
        else begin
          exp_ev = ev_q.pop_front();
          chk("abort_kind", KAbort, exp_ev.kind);
        end
      end
    end
    prev_done = (wb_done === 1'b1);
    prev_err  = (wb_error === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; core_state = 3'b000;
    set_op(1'b1, 2'b00, 4'd0, 8'h00, 8'h00);
    lsu_out = 8'h00; lsu_valid = 1'b0; wb_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'd0, wb_valid}, 0);
    chk("rst_addr", {28'd0, wb_address}, 0);
    chk("rst_data", {24'd0, wb_data}, 0);
    chk("rst_done", {31'd0, wb_done}, 0);
    chk("rst_error", {31'd0, wb_error}, 0);
    chk("rst_count", {24'd0, wb_count}, 0);
    reset = 1'b0;
    tick();

    // CONST rd=5 imm=0x2A
    set_op(1'b1, 2'b10, 4'd5, 8'h2A, 8'h00);
    ev_q.push_back(mk(KWrite, 4'd5, 8'h2A, 1'b0));
    ev_q.push_back(mk(KDone, 4'd0, 8'h00, 1'b0));
    core_state = 3'b110;
    tick();
    chk("const_valid", {31'd0, wb_valid}, 1);
    chk("const_addr", {28'd0, wb_address}, 5);
    chk("const_data", {24'd0, wb_data}, 8'h2A);
    tick();
    chk("const_done", {31'd0, wb_done}, 1);
    chk("const_count", {24'd0, wb_count}, 1);
    core_state = 3'b000;
    tick();
    chk("const_done_clr", {31'd0, wb_done}, 0);

    // LDR rd=3, load data arrives after 4 WAIT_MEM cycles
    set_op(1'b1, 2'b01, 4'd3, 8'h00, 8'h00);
    ev_q.push_back(mk(KWrite, 4'd3, 8'h7F, 1'b0));
    ev_q.push_back(mk(KDone, 4'd0, 8'h00, 1'b0));
    core_state = 3'b110;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ldr_wait_novalid", {31'd0, wb_valid}, 0);
    end
    lsu_valid = 1'b1; lsu_out = 8'h7F;
    tick();
    lsu_valid = 1'b0;
    chk("ldr_valid", {31'd0, wb_valid}, 1);
    begin
      int n = 0;
      while (wb_done !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk("ldr_done_in_time", {31'd0, wb_done}, 1);
    end
    chk("ldr_error", {31'd0, wb_error}, 0);
    chk("ldr_count", {24'd0, wb_count}, 2);
    core_state = 3'b000;
    tick();

    // Load timeout: lsu_valid never rises
    set_op(1'b1, 2'b01, 4'd7, 8'h00, 8'h00);
    ev_q.push_back(mk(KDone, 4'd0, 8'h00, 1'b1));
    core_state = 3'b110;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_not_yet", {31'd0, wb_done}, 0);
    tick();
    chk("tmo_done", {31'd0, wb_done}, 1);
    chk("tmo_error", {31'd0, wb_error}, 1);
    chk("tmo_count", {24'd0, wb_count}, 2);
    core_state = 3'b000;
    tick();

    // Illegal rd=14, then write_enable=0
    set_op(1'b1, 2'b00, 4'd14, 8'h00, 8'h66);
    ev_q.push_back(mk(KDone, 4'd0, 8'h00, 1'b1));
    core_state = 3'b110;
    tick();
    chk("ill_valid", {31'd0, wb_valid}, 0);
    chk("ill_done", {31'd0, wb_done}, 1);
    chk("ill_error", {31'd0, wb_error}, 1);
    core_state = 3'b000;
    tick();
    set_op(1'b0, 2'b00, 4'd2, 8'h00, 8'h66);
    ev_q.push_back(mk(KDone, 4'd0, 8'h00, 1'b0));
    core_state = 3'b110;
    tick();
    chk("nowe_done", {31'd0, wb_done}, 1);
    chk("nowe_error", {31'd0, wb_error}, 0);
    tick();
    chk("nowe_no_rearm", {31'd0, wb_valid}, 0);
    core_state = 3'b000;
    tick();

    // Abort: ready held low for 3 cycles, then UPDATE ends
    set_op(1'b1, 2'b00, 4'd9, 8'h00, 8'h55);
    wb_ready = 1'b0;
    ev_q.push_back(mk(KAbort, 4'd0, 8'h00, 1'b1));
    core_state = 3'b110;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abt_valid", {31'd0, wb_valid}, 1);
      chk("abt_addr", {28'd0, wb_address}, 9);
      chk("abt_data", {24'd0, wb_data}, 8'h55);
    end
    core_state = 3'b000;
    tick();
    chk("abt_err_pulse", {31'd0, wb_error}, 1);
    chk("abt_valid_clr", {31'd0, wb_valid}, 0);
    chk("abt_done", {31'd0, wb_done}, 0);
    tick();
    chk("abt_err_clr", {31'd0, wb_error}, 0);
    chk("abt_count", {24'd0, wb_count}, 2);

    // Handshake coincides with UPDATE ending
    set_op(1'b1, 2'b00, 4'd4, 8'h00, 8'h33);
    core_state = 3'b110;
    tick();
    ev_q.push_back(mk(KWrite, 4'd4, 8'h33, 1'b0));
    ev_q.push_back(mk(KDone, 4'd0, 8'h00, 1'b0));
    wb_ready = 1'b1; core_state = 3'b000;
    tick();
    chk("coin_done", {31'd0, wb_done}, 1);
    chk("coin_count", {24'd0, wb_count}, 3);
    tick();
    chk("coin_done_clr", {31'd0, wb_done}, 0);

    // enable=0 freezes a pending write
    set_op(1'b1, 2'b10, 4'd6, 8'h11, 8'h00);
    wb_ready = 1'b0; core_state = 3'b110;
    tick();
    enable = 1'b0; wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("frz_valid", {31'd0, wb_valid}, 1);
    chk("frz_count", {24'd0, wb_count}, 3);
    chk("frz_done", {31'd0, wb_done}, 0);
    ev_q.push_back(mk(KWrite, 4'd6, 8'h11, 1'b0));
    ev_q.push_back(mk(KDone, 4'd0, 8'h00, 1'b0));
    enable = 1'b1;
    tick();
    chk("frz_count_after", {24'd0, wb_count}, 4);
    core_state = 3'b000;
    tick();

    // 300 back-to-back writebacks: count saturates
    wb_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_op(1'b1, 2'b10, 4'(i % 13), 8'(i), 8'h00);
      ev_q.push_back(mk(KWrite, 4'(i % 13), 8'(i), 1'b0));
      ev_q.push_back(mk(KDone, 4'd0, 8'h00, 1'b0));
      core_state = 3'b110;
      tick(); tick();
      core_state = 3'b000;
      tick();
    end
    chk("sat_count", {24'd0, wb_count}, 255);

    // Reset while in WRITE discards the pending write
    set_op(1'b1, 2'b10, 4'd2, 8'h99, 8'h00);
    wb_ready = 1'b0; core_state = 3'b110;
    tick();
    chk("rw_valid_pre", {31'd0, wb_valid}, 1);
    reset = 1'b1;
    tick();
    chk("rw_valid", {31'd0, wb_valid}, 0);
    chk("rw_addr", {28'd0, wb_address}, 0);
    chk("rw_data", {24'd0, wb_data}, 0);
    chk("rw_done", {31'd0, wb_done}, 0);
    chk("rw_error", {31'd0, wb_error}, 0);
    chk("rw_count", {24'd0, wb_count}, 0);
    core_state = 3'b000; wb_ready = 1'b1;
    reset = 1'b0;
    tick(); tick();
    chk("scoreboard_empty", ev_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
